// File: rtl/vblank_bus_arbiter_if.sv
// Requester/memory bundle for vblank_bus_arbiter: packed per-requester write
// requests in, one-hot grant and the registered framebuffer write port out.
interface vblank_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;

  modport master (
    output req, wr_addr, wr_data,
    input  gnt, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  req, wr_addr, wr_data,
    output gnt, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/vblank_bus_arbiter.sv
// Round-robin, burst-bounded framebuffer write arbiter that only opens the port in vblank.
// Optional macro ARB_HBLANK_EN adds an hblnk input that also opens a window in every hblank.
module vblank_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 12,
  parameter int MAX_BURST    = 16,
  parameter int WIN_END_LINE = 804
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                vblnk,
`ifdef ARB_HBLANK_EN
  input  logic                hblnk,
`endif
  input  logic [10:0]         vcount,
  vblank_bus_arbiter_if.slave bus,
  output logic                frame_tick,
  output logic                overrun
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0]      NUM_REQ_V = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [10:0]         WIN_END   = 11'(WIN_END_LINE);
  localparam logic [NUM_REQ-1:0]  GNT_ONE   = NUM_REQ'(1);

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    ARB    = 2'd1,
    GRANT  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s;
  logic [IDX_W-1:0]    cur_idx_r, cur_idx_nxt_s;
  logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]    beat_cnt_r, beat_cnt_nxt_s;
  logic                mem_we_r, mem_we_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [DATA_W-1:0]   mem_data_r, mem_data_nxt_s;
  logic                overrun_r, overrun_nxt_s;
  logic                frame_tick_r, vblnk_d_r;
  logic                window_open_s, beat_s, sel_found_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic [IDX_W:0]      cand_s;
  logic [ADDR_W-1:0]   addr_arr_s [NUM_REQ];
  logic [DATA_W-1:0]   data_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g] = bus.wr_addr[g*ADDR_W +: ADDR_W];
    assign data_arr_s[g] = bus.wr_data[g*DATA_W +: DATA_W];
  end

`ifdef ARB_HBLANK_EN
  assign window_open_s = (vblnk && (vcount < WIN_END)) || (hblnk && !vblnk);
`else
  assign window_open_s = vblnk && (vcount < WIN_END);
`endif

  // Round-robin pick: first asserted request at or above ptr, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = {1'b0, ptr_r} + (IDX_W+1)'(k);
      cand_s      = (cand_s >= NUM_REQ_V) ? (cand_s - NUM_REQ_V) : cand_s;
      sel_idx_s   = (!sel_found_s && bus.req[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : sel_idx_s;
      sel_found_s = sel_found_s || bus.req[cand_s[IDX_W-1:0]];
    end
  end

  // Next-state and next-output logic for the window/arbitration FSM.
  always_comb begin
    state_nxt_s    = state_r;
    gnt_nxt_s      = gnt_r;
    cur_idx_nxt_s  = cur_idx_r;
    ptr_nxt_s      = ptr_r;
    beat_cnt_nxt_s = beat_cnt_r;
    mem_we_nxt_s   = 1'b0;
    mem_addr_nxt_s = mem_addr_r;
    mem_data_nxt_s = mem_data_r;
    overrun_nxt_s  = 1'b0;
    beat_s         = bus.req[cur_idx_r] && window_open_s;
    case (state_r)
      CLOSED: begin
        gnt_nxt_s   = '0;
        state_nxt_s = window_open_s ? ARB : CLOSED;
      end
      ARB: begin
        if (!window_open_s) begin
          state_nxt_s   = CLOSED;
          overrun_nxt_s = |bus.req;
        end else if (sel_found_s) begin
          state_nxt_s    = GRANT;
          gnt_nxt_s      = GNT_ONE << sel_idx_s;
          cur_idx_nxt_s  = sel_idx_s;
          beat_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = ARB;
        end
      end
      GRANT: begin
        if (beat_s) begin
          mem_we_nxt_s   = 1'b1;
          mem_addr_nxt_s = addr_arr_s[cur_idx_r];
          mem_data_nxt_s = data_arr_s[cur_idx_r];
          beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
        // A missing beat covers both a dropped request and a closing window.
        if (!beat_s || (beat_cnt_r == LAST_BEAT)) begin
          state_nxt_s   = window_open_s ? ARB : CLOSED;
          overrun_nxt_s = !window_open_s && (|bus.req);
          gnt_nxt_s     = '0;
          ptr_nxt_s     = (cur_idx_r == LAST_IDX) ? '0 : (cur_idx_r + IDX_W'(1));
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = CLOSED;
        gnt_nxt_s   = '0;
      end
    endcase
  end

  // FSM, grant and memory-port registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r    <= CLOSED;
      gnt_r      <= '0;
      cur_idx_r  <= '0;
      ptr_r      <= '0;
      beat_cnt_r <= '0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gnt_r      <= gnt_nxt_s;
      cur_idx_r  <= cur_idx_nxt_s;
      ptr_r      <= ptr_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      mem_we_r   <= mem_we_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      mem_data_r <= mem_data_nxt_s;
      overrun_r  <= overrun_nxt_s;
    end
  end

  // Vblank rising-edge tick; tracking vblnk through reset suppresses a tick on release.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d_r    <= vblnk;
      frame_tick_r <= 1'b0;
    end else begin
      vblnk_d_r    <= vblnk;
      frame_tick_r <= vblnk && !vblnk_d_r;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_data = mem_data_r;
  assign frame_tick   = frame_tick_r;
  assign overrun      = overrun_r;
endmodule

// File: tb/tb_vblank_bus_arbiter.sv
// Directed table-driven bench for vblank_bus_arbiter plus hand-written sequences
// for reset mid-burst and a long all-request window with burst rotation.
module tb_vblank_bus_arbiter;
  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk;
`ifdef ARB_HBLANK_EN
  logic        hblnk;
`endif
  logic [10:0] vcount;
  logic        frame_tick;
  logic        overrun;
  int          checks = 0;
  int          errors = 0;

  vblank_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(12)) bus_if ();

  vblank_bus_arbiter #(
    .NUM_REQ(4), .ADDR_W(16), .DATA_W(12), .MAX_BURST(16), .WIN_END_LINE(804)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk      (vblnk),
`ifdef ARB_HBLANK_EN
    .hblnk      (hblnk),
`endif
    .vcount     (vcount),
    .bus        (bus_if),
    .frame_tick (frame_tick),
    .overrun    (overrun)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        rst;
    logic        vblnk;
    logic [10:0] vcount;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        we;
    logic [15:0] addr;
    logic [11:0] data;
    logic        tick;
    logic        ovr;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic we,
                           input logic [15:0] a, input logic [11:0] d,
                           input logic tk, input logic ov);
    check({tag, " gnt"},        32'(bus_if.gnt),      32'(g));
    check({tag, " mem_we"},     32'(bus_if.mem_we),   32'(we));
    check({tag, " mem_addr"},   32'(bus_if.mem_addr), 32'(a));
    check({tag, " mem_data"},   32'(bus_if.mem_data), 32'(d));
    check({tag, " frame_tick"}, 32'(frame_tick),      32'(tk));
    check({tag, " overrun"},    32'(overrun),         32'(ov));
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_fixed();
    bus_if.wr_addr = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    bus_if.wr_data = {12'h303, 12'h302, 12'h301, 12'h300};
  endtask

  task automatic drive_tagged(input int tag);
    for (int i = 0; i < 4; i++) begin
      bus_if.wr_addr[i*16 +: 16] = {4'(i), 12'(tag)};
      bus_if.wr_data[i*12 +: 12] = {4'(i), 8'(tag)};
    end
  endtask

  // Expected grant for the all-request window: 16 granted cycles then one idle, rotating 0..3.
  function automatic logic [3:0] burst_gnt(input int c);
    int o;
    int b;
    logic [3:0] one;
    one = 4'b0001;
    if (c < 2) return 4'b0000;
    o = (c - 2) % 17;
    b = (c - 2) / 17;
    return (o < 16) ? (one << (b % 4)) : 4'b0000;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    logic [3:0]  prev_g;
    logic [3:0]  g;
    logic        we;
    logic [15:0] exp_a;
    logic [11:0] exp_d;

    // rst, vblnk, vcount, req | gnt, we, addr, data, tick, ovr
    vecs[0]  = '{1'b1, 1'b1, 11'd770, 4'b1111, 4'b0000, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 11'd770, 4'b1111, 4'b0000, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 11'd770, 4'b1111, 4'b0000, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 11'd770, 4'b1111, 4'b0001, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 11'd770, 4'b1111, 4'b0001, 1'b1, 16'hA000, 12'h300, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 11'd770, 4'b0000, 4'b0000, 1'b0, 16'hA000, 12'h300, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 11'd770, 4'b0000, 4'b0000, 1'b0, 16'hA000, 12'h300, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 11'd770, 4'b1010, 4'b0010, 1'b0, 16'hA000, 12'h300, 1'b0, 1'b0};
    for (int i = 8; i <= 12; i++)
      vecs[i] = '{1'b0, 1'b1, 11'd770, 4'b1010, 4'b0010, 1'b1, 16'hA001, 12'h301, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 11'd770, 4'b1000, 4'b0000, 1'b0, 16'hA001, 12'h301, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 11'd770, 4'b1000, 4'b1000, 1'b0, 16'hA001, 12'h301, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 11'd770, 4'b1000, 4'b1000, 1'b1, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 11'd770, 4'b0001, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 11'd770, 4'b0001, 4'b0001, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 11'd804, 4'b0001, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 11'd805, 4'b0001, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 11'd0,   4'b0100, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 11'd767, 4'b0100, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 11'd768, 4'b0100, 4'b0000, 1'b0, 16'hA003, 12'h303, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 11'd768, 4'b0100, 4'b0100, 1'b0, 16'hA003, 12'h303, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 11'd768, 4'b0100, 4'b0100, 1'b1, 16'hA002, 12'h302, 1'b0, 1'b0};

`ifdef ARB_HBLANK_EN
    hblnk = 1'b0;
`endif
    drive_fixed();
    for (int i = 0; i < 25; i++) begin
      rst        = vecs[i].rst;
      vblnk      = vecs[i].vblnk;
      vcount     = vecs[i].vcount;
      bus_if.req = vecs[i].req;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].we, vecs[i].addr,
                vecs[i].data, vecs[i].tick, vecs[i].ovr);
    end

    // Requester 2 continues to beat 7 (searched from ptr=1), then a one-cycle reset.
    for (int b = 2; b <= 7; b++) begin
      bus_if.req = 4'b0100;
      step();
      check_all($sformatf("burst2 beat%0d", b), 4'b0100, 1'b1, 16'hA002, 12'h302, 1'b0, 1'b0);
    end
    rst = 1'b1;
    bus_if.req = 4'b0101;
    step();
    check_all("midreset", 4'b0000, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_reset1", 4'b0000, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
    step();
    check_all("post_reset2", 4'b0001, 1'b0, 16'h0000, 12'h000, 1'b0, 1'b0);
    step();
    check_all("post_reset3", 4'b0001, 1'b1, 16'hA000, 12'h300, 1'b0, 1'b0);

    // All four requesting for a long window: rotation with 16-beat bursts.
    rst = 1'b1;
    vblnk = 1'b1;
    vcount = 11'd780;
    bus_if.req = 4'b1111;
    step();
    rst = 1'b0;
    prev_g = 4'b0000;
    exp_a = 16'h0000;
    exp_d = 12'h000;
    for (int c = 1; c <= 80; c++) begin
      drive_tagged(c);
      step();
      g  = burst_gnt(c);
      we = (prev_g != 4'b0000);
      if (we) begin
        exp_a = {4'(onehot_idx(prev_g)), 12'(c)};
        exp_d = {4'(onehot_idx(prev_g)), 8'(c)};
      end
      check_all($sformatf("rot c%0d", c), g, we, exp_a, exp_d, 1'b0, 1'b0);
      prev_g = g;
    end
    drive_tagged(81);
    vcount = 11'd804;
    step();
    check_all("win_close", 4'b0000, 1'b0, exp_a, exp_d, 1'b0, 1'b1);
    vcount = 11'd805;
    step();
    check_all("after_close", 4'b0000, 1'b0, exp_a, exp_d, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
